// File: rtl/mem_io_bus_ctrl.sv
// mem_io_bus_ctrl: memory-mapped fabric between processor, synchronous RAM, output registers and switch input.
// Reads return on DIN one cycle after the address, for every region alike.
module mem_io_bus_ctrl #(
    parameter int DW        = 9,
    parameter int AW        = 9,
    parameter int RAM_AW    = 7,
    parameter int N_OUT     = 2,
    parameter int RUN_DELAY = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    output logic                Run_proc,
    input  logic [AW-1:0]       ADDR,
    input  logic [DW-1:0]       DOUT,
    input  logic                W,
    output logic [DW-1:0]       DIN,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DW-1:0]       ram_wdata,
    output logic                ram_wren,
    input  logic [DW-1:0]       ram_q,
    input  logic [DW-1:0]       SW,
    output logic [N_OUT*DW-1:0] out_regs,
    input  logic                err_clr,
    output logic                bus_err
);
    localparam int OIW = N_OUT > 1 ? $clog2(N_OUT) : 1;
    logic [1:0] region, sel_q;
    logic [OIW-1:0] idx;
    logic out_ok, illegal;
    logic [DW-1:0] regs [N_OUT];
    logic [DW-1:0] sw_m, sw_s, rd_q, rd_d;
    logic [RUN_DELAY-1:0] run_sr;
    always_comb begin
        region = ADDR[AW-1:AW-2];
        idx = ADDR[OIW-1:0];
        out_ok = 32'(idx) < N_OUT;
        illegal = (W & region[1]) | (region == 2'b01 & !out_ok);
        rd_d = (region == 2'b01 && out_ok) ? regs[idx] : region == 2'b10 ? sw_s : '0;
    end
    assign ram_addr = ADDR[RAM_AW-1:0];
    assign ram_wdata = DOUT;
    assign ram_wren = W & (region == 2'b00);
    assign DIN = sel_q == 2'b00 ? ram_q : rd_q;
    assign Run_proc = run_sr[RUN_DELAY-1];
    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_regs[k*DW +: DW] = regs[k];
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < N_OUT; k++) regs[k] <= '0;
            sw_m <= '0;
            sw_s <= '0;
            sel_q <= 2'b00;
            rd_q <= '0;
            bus_err <= 1'b0;
            run_sr <= '0;
        end else begin
            if (W && region == 2'b01 && out_ok) regs[idx] <= DOUT;
            sw_m <= SW;
            sw_s <= sw_m;
            sel_q <= region;
            rd_q <= rd_d;
            // a new illegal access outranks a clear in the same cycle
            bus_err <= illegal ? 1'b1 : err_clr ? 1'b0 : bus_err;
            run_sr <= RUN_DELAY'({run_sr, Run});
        end
    end
endmodule

// File: tb/tb_mem_io_bus_ctrl.sv
// tb_mem_io_bus_ctrl: scoreboard bench for mem_io_bus_ctrl with a synchronous RAM model.
// A second instance with N_OUT=3 covers out-of-range register indices.
module tb_mem_io_bus_ctrl;
    localparam int RD = 2;
    logic clk = 1'b0;
    logic Reset, Run, W, err_clr;
    logic [8:0] ADDR, DOUT, SW;
    logic run_proc, bus_err, ram_wren, rp3, err3, we3;
    logic [8:0] din, din3, ram_wdata, rw3;
    logic [6:0] ram_addr, ra3;
    logic [17:0] out_regs;
    logic [26:0] out3;
    logic [8:0] mem [128];
    logic [8:0] ram_q;
    int checks = 0, errors = 0, cyc = 0;
    typedef struct {string tag; logic [8:0] exp; int cyc;} rd_t;
    rd_t sb[$];

    always #5 clk = ~clk;

    mem_io_bus_ctrl dut (.Clock(clk), .Reset(Reset), .Run(Run), .Run_proc(run_proc), .ADDR(ADDR),
        .DOUT(DOUT), .W(W), .DIN(din), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .ram_q(ram_q), .SW(SW), .out_regs(out_regs), .err_clr(err_clr), .bus_err(bus_err));

    mem_io_bus_ctrl #(.N_OUT(3)) dut3 (.Clock(clk), .Reset(Reset), .Run(Run), .Run_proc(rp3), .ADDR(ADDR),
        .DOUT(DOUT), .W(W), .DIN(din3), .ram_addr(ra3), .ram_wdata(rw3), .ram_wren(we3),
        .ram_q(ram_q), .SW(SW), .out_regs(out3), .err_clr(err_clr), .bus_err(err3));

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        ram_q = '0;
    end

    // read-old-data synchronous RAM
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [8:0] a, input logic w, input logic [8:0] d,
                         input logic [8:0] exp);
        @(negedge clk);
        ADDR = a;
        W = w;
        DOUT = d;
        sb.push_back('{tag, exp, cyc});
    endtask

    always @(negedge clk)
        while (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
            chk(sb[0].tag, din, sb[0].exp);
            void'(sb.pop_front());
        end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1; Run = 0; ADDR = 0; DOUT = 0; W = 0; SW = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        chk("rst_run_proc", run_proc, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_out", out_regs, 0);
        chk("rst_out3", out3, 0);
        @(negedge clk); ADDR = 9'h005; W = 1; DOUT = 9'h0AA;
        #1 chk("rst_ram_wren", ram_wren, 1);
        @(negedge clk); W = 0;
        @(negedge clk); chk("rst_din_ram", din, 9'h0AA);
        Reset = 0;
        // Run pulse
        @(negedge clk); Run = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); Run = 0;
            chk($sformatf("run_%0d", i), run_proc, 32'(i == RD));
        end
        // reset discards a pending Run
        @(negedge clk); Run = 1;
        @(negedge clk); Run = 0;
        #2 Reset = 1;
        @(negedge clk); Reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_rst_cancel", run_proc, 0);
        end
        // RAM write and readback
        issue("ram_wr", 9'h005, 1, 9'h1A5, 9'h0AA);
        #1 chk("ram_wren", ram_wren, 1);
        chk("ram_addr", ram_addr, 7'h05);
        chk("ram_wdata", ram_wdata, 9'h1A5);
        issue("ram_rd", 9'h005, 0, 0, 9'h1A5);
        // output register write: same-cycle read sees the old value
        issue("out_wr", 9'h081, 1, 9'h0F0, 9'h000);
        #1 chk("out_ram_wren", ram_wren, 0);
        issue("out_rd1", 9'h081, 0, 0, 9'h0F0);
        chk("out_reg0", out_regs[8:0], 9'h000);
        chk("out_reg1", out_regs[17:9], 9'h0F0);
        issue("out_rd0", 9'h080, 0, 0, 9'h000);
        // switch synchroniser lag
        issue("sw_lag0", 9'h100, 0, 0, 9'h000); SW = 9'h155;
        issue("sw_lag1", 9'h100, 0, 0, 9'h000);
        issue("sw_ok", 9'h100, 0, 0, 9'h155);
        issue("sw_wr", 9'h100, 1, 9'h1FF, 9'h155);
        issue("sw_after", 9'h080, 0, 0, 9'h000);
        chk("sw_wr_err", bus_err, 1);
        chk("sw_wr_out", out_regs, {9'h0F0, 9'h000});
        // error clear and priority
        issue("clr_rd", 9'h080, 0, 0, 9'h000); err_clr = 1;
        issue("clr_next", 9'h080, 0, 0, 9'h000); err_clr = 0;
        chk("clr_err", bus_err, 0);
        issue("unm_wr", 9'h1C0, 1, 9'h123, 9'h000);
        issue("unm_rd", 9'h1C0, 0, 0, 9'h000);
        chk("unm_err", bus_err, 1);
        issue("both", 9'h1C0, 1, 9'h001, 9'h000); err_clr = 1;
        issue("both_next", 9'h080, 0, 0, 9'h000); err_clr = 0;
        chk("both_err", bus_err, 1);
        issue("clr2", 9'h080, 0, 0, 9'h000); err_clr = 1;
        issue("clr2_next", 9'h080, 0, 0, 9'h000); err_clr = 0;
        chk("clr2_err", bus_err, 0);
        chk("clr2_err3", err3, 0);
        // N_OUT=3 index range; the N_OUT=2 instance decodes only ADDR[0]
        issue("n3_wr2", 9'h082, 1, 9'h033, 9'h000);
        issue("n3_wr3", 9'h083, 1, 9'h1FF, 9'h0F0);
        chk("n3_reg2", out3[26:18], 9'h033);
        issue("n3_rd3", 9'h083, 0, 0, 9'h1FF);
        chk("n3_err3", err3, 1);
        chk("n3_err", bus_err, 0);
        chk("n3_out3", out3, {9'h033, 9'h0F0, 9'h000});
        chk("n3_out", out_regs, {9'h1FF, 9'h033});
        chk("n3_din3_wr", din3, 9'h000);
        issue("n3_rd2", 9'h082, 0, 0, 9'h033);
        chk("n3_din3_rd3", din3, 9'h000);
        @(negedge clk);
        chk("n3_din3_rd2", din3, 9'h033);
        // asynchronous reset mid-cycle
        #2 Reset = 1;
        #1 chk("rst2_run_proc", run_proc, 0);
        chk("rst2_err", bus_err, 0);
        chk("rst2_err3", err3, 0);
        chk("rst2_out", out_regs, 0);
        chk("rst2_out3", out3, 0);
        chk("rst2_din", din, 9'h000);
        chk("rst2_ram_addr", ram_addr, 7'h02);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
